// File: rtl/i2c_master_byte_ctrl_pkg.sv
// Shared definitions for the I2C byte-level master sequencer.
// Contains the 4-bit bit-controller command encodings and the byte FSM state type.
package i2c_master_byte_ctrl_pkg;

    localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
    localparam logic [3:0] I2C_CMD_START = 4'b0001;
    localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
    localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
    localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_READ,
        ST_WRITE,
        ST_ACK,
        ST_STOP
    } state_t;

endpackage

// File: rtl/i2c_master_byte_ctrl.sv
// I2C byte-level master sequencer: turns byte requests into bit-controller commands.
// Optional bit-ack watchdog enabled by defining I2C_BYTE_TIMEOUT_EN.
module i2c_master_byte_ctrl
    import i2c_master_byte_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ena_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       read_i,
    input  logic       write_i,
    input  logic       ack_in_i,
    input  logic [7:0] din_i,
    output logic       cmd_ack_o,
    output logic       ack_out_o,
    output logic [7:0] dout_o,
    output logic       i2c_busy_o,
    output logic       i2c_al_o,
    output logic       timeout_o,
    output logic [3:0] bit_cmd_o,
    input  logic       bit_ack_i,
    input  logic       bit_al_i,
    input  logic       bit_busy_i,
    output logic       bit_txd_o,
    input  logic       bit_rxd_i
);

    state_t     state, state_next;
    logic [3:0] cmd, cmd_next;
    logic [7:0] sr, sr_next;
    logic [2:0] cnt, cnt_next;
    logic       cmd_ack, cmd_ack_next;
    logic       ack_out, ack_out_next;
    logic       txd, txd_next;
    logic       tout, tout_next;
    logic       go, cnt_done, abort, timeout_hit;

`ifdef I2C_BYTE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tcnt;

    // Watchdog restarts on every completed bit command and whenever the FSM rests in IDLE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            tcnt <= '0;
        else if (bit_ack_i || state == ST_IDLE)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    assign timeout_hit = (state != ST_IDLE) && (&tcnt) && !bit_ack_i;
`else
    assign timeout_hit = 1'b0;
`endif

    // A request held across cmd_ack must not restart a transfer in the ack cycle.
    assign go       = (read_i | write_i | stop_i) & ~cmd_ack;
    assign cnt_done = (cnt == 3'd0);
    assign abort    = bit_al_i | ~ena_i | timeout_hit;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next   = state;
        cmd_next     = cmd;
        sr_next      = sr;
        cnt_next     = cnt;
        cmd_ack_next = 1'b0;
        ack_out_next = ack_out;
        txd_next     = txd;
        tout_next    = timeout_hit;

        if (abort) begin
            state_next = ST_IDLE;
            cmd_next   = I2C_CMD_NOP;
            sr_next    = 8'h00;
            cnt_next   = 3'd0;
        end else begin
            case (state)
                ST_IDLE: if (go) begin
                    sr_next  = din_i;
                    cnt_next = 3'd7;
                    txd_next = 1'b1;
                    if (start_i) begin
                        state_next = ST_START;
                        cmd_next   = I2C_CMD_START;
                    end else if (read_i) begin
                        state_next = ST_READ;
                        cmd_next   = I2C_CMD_READ;
                    end else if (write_i) begin
                        state_next = ST_WRITE;
                        cmd_next   = I2C_CMD_WRITE;
                        txd_next   = din_i[7];
                    end else begin
                        state_next = ST_STOP;
                        cmd_next   = I2C_CMD_STOP;
                    end
                end
                ST_START: if (bit_ack_i) begin
                    sr_next  = din_i;
                    cnt_next = 3'd7;
                    if (read_i) begin
                        state_next = ST_READ;
                        cmd_next   = I2C_CMD_READ;
                        txd_next   = 1'b1;
                    end else begin
                        state_next = ST_WRITE;
                        cmd_next   = I2C_CMD_WRITE;
                        txd_next   = din_i[7];
                    end
                end
                ST_WRITE: if (bit_ack_i) begin
                    if (cnt_done) begin
                        state_next = ST_ACK;
                        cmd_next   = I2C_CMD_READ;
                        txd_next   = 1'b1;
                    end else begin
                        sr_next  = {sr[6:0], bit_rxd_i};
                        cnt_next = cnt - 3'd1;
                        cmd_next = I2C_CMD_WRITE;
                        txd_next = sr[6];
                    end
                end
                ST_READ: if (bit_ack_i) begin
                    sr_next = {sr[6:0], bit_rxd_i};
                    if (cnt_done) begin
                        state_next = ST_ACK;
                        cmd_next   = I2C_CMD_WRITE;
                        txd_next   = ack_in_i;
                    end else begin
                        cnt_next = cnt - 3'd1;
                        cmd_next = I2C_CMD_READ;
                        txd_next = 1'b1;
                    end
                end
                ST_ACK: if (bit_ack_i) begin
                    ack_out_next = bit_rxd_i;
                    txd_next     = 1'b1;
                    if (stop_i) begin
                        state_next = ST_STOP;
                        cmd_next   = I2C_CMD_STOP;
                    end else begin
                        state_next   = ST_IDLE;
                        cmd_next     = I2C_CMD_NOP;
                        cmd_ack_next = 1'b1;
                    end
                end
                ST_STOP: if (bit_ack_i) begin
                    state_next   = ST_IDLE;
                    cmd_next     = I2C_CMD_NOP;
                    cmd_ack_next = 1'b1;
                    txd_next     = 1'b1;
                end
                default: begin
                    state_next = ST_IDLE;
                    cmd_next   = I2C_CMD_NOP;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            cmd     <= I2C_CMD_NOP;
            sr      <= 8'h00;
            cnt     <= 3'd0;
            cmd_ack <= 1'b0;
            ack_out <= 1'b0;
            txd     <= 1'b0;
            tout    <= 1'b0;
        end else begin
            state   <= state_next;
            cmd     <= cmd_next;
            sr      <= sr_next;
            cnt     <= cnt_next;
            cmd_ack <= cmd_ack_next;
            ack_out <= ack_out_next;
            txd     <= txd_next;
            tout    <= tout_next;
        end
    end

    assign cmd_ack_o  = cmd_ack;
    assign ack_out_o  = ack_out;
    assign dout_o     = sr;
    assign bit_cmd_o  = cmd;
    assign bit_txd_o  = txd;
    assign timeout_o  = tout;
    assign i2c_busy_o = bit_busy_i;
    assign i2c_al_o   = bit_al_i;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Self-checking bench for i2c_master_byte_ctrl: table of byte requests against a
// bit-controller responder, with a queue of expected bit commands as scoreboard.
module tb_i2c_master_byte_ctrl;

`ifdef I2C_BYTE_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 16;
`endif

    localparam logic [3:0] C_NOP   = 4'b0000;
    localparam logic [3:0] C_START = 4'b0001;
    localparam logic [3:0] C_STOP  = 4'b0010;
    localparam logic [3:0] C_WRITE = 4'b0100;
    localparam logic [3:0] C_READ  = 4'b1000;

    logic       clk_i = 1'b0;
    logic       rst_n_i, ena_i, start_i, stop_i, read_i, write_i, ack_in_i;
    logic [7:0] din_i;
    logic       cmd_ack_o, ack_out_o, i2c_busy_o, i2c_al_o, timeout_o, bit_txd_o;
    logic [7:0] dout_o;
    logic [3:0] bit_cmd_o;
    logic       bit_ack_i, bit_al_i, bit_busy_i, bit_rxd_i;

    i2c_master_byte_ctrl #(.TIMEOUT_W(TW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ena_i(ena_i),
        .start_i(start_i), .stop_i(stop_i), .read_i(read_i), .write_i(write_i),
        .ack_in_i(ack_in_i), .din_i(din_i),
        .cmd_ack_o(cmd_ack_o), .ack_out_o(ack_out_o), .dout_o(dout_o),
        .i2c_busy_o(i2c_busy_o), .i2c_al_o(i2c_al_o), .timeout_o(timeout_o),
        .bit_cmd_o(bit_cmd_o), .bit_ack_i(bit_ack_i), .bit_al_i(bit_al_i),
        .bit_busy_i(bit_busy_i), .bit_txd_o(bit_txd_o), .bit_rxd_i(bit_rxd_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] cmd;
        logic       txd;
        logic       txd_chk;
        logic       rx;
    } exp_t;

    typedef struct {
        string      name;
        logic       start, stop, read, write, ack_in;
        logic [7:0] din, rx_byte;
        logic       slave_ack;
        logic       hold;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   total = 0;
    int   bad = 0;
    logic exp_ack_out = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drop_requests();
        start_i = 0; stop_i = 0; read_i = 0; write_i = 0;
    endtask

    // Expected bit-command stream for one byte request, derived from the request alone.
    function automatic void build(input vec_t v);
        if (v.start) exp_q.push_back('{cmd: C_START, txd: 1'b0, txd_chk: 1'b0, rx: 1'b0});
        if (v.read) begin
            for (int i = 7; i >= 0; i--)
                exp_q.push_back('{cmd: C_READ, txd: 1'b1, txd_chk: 1'b1, rx: v.rx_byte[i]});
            exp_q.push_back('{cmd: C_WRITE, txd: v.ack_in, txd_chk: 1'b1, rx: v.ack_in});
        end else if (v.write) begin
            for (int i = 7; i >= 0; i--)
                exp_q.push_back('{cmd: C_WRITE, txd: v.din[i], txd_chk: 1'b1, rx: 1'b0});
            exp_q.push_back('{cmd: C_READ, txd: 1'b1, txd_chk: 1'b1, rx: v.slave_ack});
        end
        if (v.stop) exp_q.push_back('{cmd: C_STOP, txd: 1'b0, txd_chk: 1'b0, rx: 1'b0});
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t cur;
        int   wait_n = 0;
        logic busy = 0, acked_prev = 0, prev, done = 0;
        cur = '{cmd: C_NOP, txd: 1'b0, txd_chk: 1'b0, rx: 1'b0};
        build(v);
        if (v.read || v.write) exp_ack_out = v.read ? v.ack_in : v.slave_ack;
        start_i = v.start; stop_i = v.stop; read_i = v.read; write_i = v.write;
        ack_in_i = v.ack_in; din_i = v.din;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(posedge clk_i); #1;
            bit_ack_i = 0;
            prev = acked_prev;
            acked_prev = 0;
            if (cmd_ack_o) begin
                check({v.name, " ack_latency"}, prev, 1);
                check({v.name, " cmds_left"}, exp_q.size(), 0);
                check({v.name, " nop_at_ack"}, bit_cmd_o, C_NOP);
                if (!v.hold) drop_requests();
                done = 1;
            end else if (busy) begin
                check({v.name, " cmd_held"}, bit_cmd_o, cur.cmd);
                if (wait_n == 0) begin
                    bit_ack_i = 1; bit_rxd_i = cur.rx; busy = 0; acked_prev = 1;
                end else begin
                    wait_n--;
                end
            end else if (bit_cmd_o != C_NOP) begin
                if (exp_q.size() == 0) begin
                    check({v.name, " extra_cmd"}, bit_cmd_o, C_NOP);
                end else begin
                    cur = exp_q.pop_front();
                    check({v.name, " bit_cmd"}, bit_cmd_o, cur.cmd);
                    if (cur.txd_chk) check({v.name, " bit_txd"}, bit_txd_o, cur.txd);
                    busy = 1;
                    wait_n = cyc % 3;
                end
            end
        end
        if (!done) begin
            check({v.name, " cmd_ack_never_came"}, 0, 1);
            exp_q.delete();
            drop_requests();
        end
        if (v.hold) begin
            @(posedge clk_i); #1;
            check({v.name, " no_restart"}, bit_cmd_o, C_NOP);
            drop_requests();
        end
        @(posedge clk_i); #1;
        check({v.name, " single_pulse"}, cmd_ack_o, 0);
        check({v.name, " ack_out"}, ack_out_o, exp_ack_out);
        if (v.read) check({v.name, " dout"}, dout_o, v.rx_byte);
    endtask

    // kind 1: arbitration lost during a write; kind 2: enable dropped during a read.
    task automatic run_abort(input int kind);
        int         n = 0, wait_n = 0;
        logic       busy = 0, fired = 0, saw_ack = 0;
        logic [3:0] cur = C_NOP;
        start_i = (kind == 1); write_i = (kind == 1); read_i = (kind == 2);
        din_i = 8'h5A; ack_in_i = 0;
        for (int cyc = 0; cyc < 200 && !fired; cyc++) begin
            @(posedge clk_i); #1;
            bit_ack_i = 0;
            if (n == 3) begin
                if (kind == 1) begin
                    bit_al_i = 1; #1;
                    check("al_passthrough", i2c_al_o, 1);
                end else begin
                    ena_i = 0;
                end
                fired = 1;
            end else if (busy) begin
                if (wait_n == 0) begin
                    bit_ack_i = 1; bit_rxd_i = 1; busy = 0;
                    if (cur == C_READ || cur == C_WRITE) n++;
                end else begin
                    wait_n--;
                end
            end else if (bit_cmd_o != C_NOP) begin
                cur = bit_cmd_o; busy = 1; wait_n = 1;
            end
        end
        check("abort_reached", fired, 1);
        @(posedge clk_i); #1;
        bit_al_i = 0; ena_i = 1;
        drop_requests();
        check("abort_cmd_nop", bit_cmd_o, C_NOP);
        check("abort_sr_clear", dout_o, 8'h00);
        check("abort_ack_out_kept", ack_out_o, exp_ack_out);
        if (kind == 1) check("al_follows_low", i2c_al_o, 0);
        for (int i = 0; i < 4; i++) begin
            if (cmd_ack_o) saw_ack = 1;
            @(posedge clk_i); #1;
        end
        check("abort_no_cmd_ack", saw_ack, 0);
        check("abort_stays_idle", bit_cmd_o, C_NOP);
    endtask

    task automatic run_stall();
        int   n = 0;
        logic seen = 0, hit = 0;
        write_i = 1; din_i = 8'hFF;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk_i); #1;
            seen = (bit_cmd_o == C_WRITE);
        end
        check("stall_write_issued", seen, 1);
`ifdef I2C_BYTE_TIMEOUT_EN
        for (int i = 1; i <= 40 && !hit; i++) begin
            @(posedge clk_i); #1;
            if (timeout_o) begin
                hit = 1; n = i;
            end
        end
        drop_requests();
        check("timeout_fired", hit, 1);
        check("timeout_latency", (n == 15 || n == 16), 1);
        check("timeout_idle", bit_cmd_o, C_NOP);
        @(posedge clk_i); #1;
        check("timeout_one_pulse", timeout_o, 0);
        check("timeout_no_cmd_ack", cmd_ack_o, 0);
`else
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (timeout_o || bit_cmd_o != C_WRITE) hit = 1;
        end
        check("no_watchdog", hit, 0);
        ena_i = 0;
        drop_requests();
        @(posedge clk_i); #1;
        ena_i = 1;
        check("ena_low_idle", bit_cmd_o, C_NOP);
`endif
    endtask

    initial begin
        vecs[0] = '{name: "start_wr_a5", start: 1, stop: 0, read: 0, write: 1, ack_in: 0,
                    din: 8'hA5, rx_byte: 8'h00, slave_ack: 0, hold: 0};
        vecs[1] = '{name: "rd_3c_stop", start: 0, stop: 1, read: 1, write: 0, ack_in: 1,
                    din: 8'h00, rx_byte: 8'h3C, slave_ack: 0, hold: 0};
        vecs[2] = '{name: "stop_only", start: 0, stop: 1, read: 0, write: 0, ack_in: 0,
                    din: 8'h00, rx_byte: 8'h00, slave_ack: 0, hold: 0};
        vecs[3] = '{name: "wr_nack", start: 0, stop: 0, read: 0, write: 1, ack_in: 0,
                    din: 8'h81, rx_byte: 8'h00, slave_ack: 1, hold: 0};
        vecs[4] = '{name: "start_rd_c3_stop_hold", start: 1, stop: 1, read: 1, write: 0, ack_in: 0,
                    din: 8'hFF, rx_byte: 8'hC3, slave_ack: 0, hold: 1};
        vecs[5] = '{name: "wr_00_hold", start: 0, stop: 0, read: 0, write: 1, ack_in: 0,
                    din: 8'h00, rx_byte: 8'h00, slave_ack: 0, hold: 1};
        vecs[6] = '{name: "start_wr_ff_stop_nack", start: 1, stop: 1, read: 0, write: 1, ack_in: 0,
                    din: 8'hFF, rx_byte: 8'h00, slave_ack: 1, hold: 0};

        rst_n_i = 0; ena_i = 1; drop_requests(); ack_in_i = 0; din_i = 8'h00;
        bit_ack_i = 0; bit_al_i = 0; bit_busy_i = 0; bit_rxd_i = 0;
        #12;
        check("rst bit_cmd", bit_cmd_o, C_NOP);
        check("rst cmd_ack", cmd_ack_o, 0);
        check("rst ack_out", ack_out_o, 0);
        check("rst txd", bit_txd_o, 0);
        check("rst timeout", timeout_o, 0);
        check("rst dout", dout_o, 8'h00);
        @(posedge clk_i); #1;
        rst_n_i = 1;

        bit_busy_i = 1; #1;
        check("busy_passthrough_hi", i2c_busy_o, 1);
        bit_busy_i = 0; #1;
        check("busy_passthrough_lo", i2c_busy_o, 0);

        @(posedge clk_i); #1;
        bit_ack_i = 1;
        @(posedge clk_i); #1;
        bit_ack_i = 0;
        check("idle_ack_ignored_cmd", bit_cmd_o, C_NOP);
        check("idle_ack_ignored_ack", cmd_ack_o, 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            @(posedge clk_i); #1;
        end

        run_abort(1);
        run_abort(2);
        run_stall();

        write_i = 1; din_i = 8'h55;
        repeat (3) @(posedge clk_i);
        #1;
        check("pre_reset_write", bit_cmd_o, C_WRITE);
        rst_n_i = 0; #1;
        check("async_reset_cmd", bit_cmd_o, C_NOP);
        check("async_reset_dout", dout_o, 8'h00);
        drop_requests();
        @(posedge clk_i); #1;
        rst_n_i = 1;
        @(posedge clk_i); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_master_byte_ctrl.md
Name: i2c_master_byte_ctrl

Overview:
Byte-level I2C master sequencer, directly upstream of the bit controller. Turns register-level requests (start, write, read, stop, ack value) into a sequence of 4-bit bit-level commands. Shifts 8 data bits out or in MSB-first, then handles the ACK bit. Returns a single-cycle completion pulse, the received byte and the received ACK to the control/register layer. Passes bus busy and arbitration-lost through.

Parameters:
TIMEOUT_W, 16, width of the bit-ack watchdog counter (used only with the optional feature).

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous, active-low
ena_i  in  1  core enable; low forces FSM to idle
start_i  in  1  generate START before the byte
stop_i  in  1  generate STOP after the byte
read_i  in  1  read one byte
write_i  in  1  write one byte
ack_in_i  in  1  ACK value master drives after a read (0 = ACK)
din_i  in  8  byte to transmit
cmd_ack_o  out  1  request complete, 1-cycle pulse
ack_out_o  out  1  ACK bit sampled from slave after a write
dout_o  out  8  received byte (shift register contents)
i2c_busy_o  out  1  bus busy (pass-through of bit_busy_i)
i2c_al_o  out  1  arbitration lost (pass-through of bit_al_i)
timeout_o  out  1  bit-ack watchdog expired, 1-cycle pulse
bit_cmd_o  out  4  command to bit ctrl (I2C_CMD_* encoding)
bit_ack_i  in  1  bit command complete
bit_al_i  in  1  arbitration lost from bit ctrl
bit_busy_i  in  1  bus busy from bit ctrl
bit_txd_o  out  1  bit to drive (bit ctrl dat_i)
bit_rxd_i  in  1  sampled bit (bit ctrl dat_o)

Behaviour:
- Reset values: state IDLE; bit_cmd_o = I2C_CMD_NOP; shift reg 8'h00; bit counter 0; cmd_ack_o 0; ack_out_o 0; bit_txd_o 0; timeout_o 0.
- Command encoding: NOP 4'b0000, START 4'b0001, STOP 4'b0010, WRITE 4'b0100, READ 4'b1000.
- go = (read_i | write_i | stop_i) & ~cmd_ack_o. Requests stay asserted until cmd_ack_o. go is suppressed in the cycle of cmd_ack_o.
- bit_cmd_o changes only in IDLE on go, or in the cycle bit_ack_i is high. It is held otherwise.
- Shift register and bit counter:
  - Load: sr <= din_i, cnt <= 7.
  - Shift: sr <= {sr[6:0], bit_rxd_i}, cnt <= cnt - 1.
  - cnt_done = (cnt == 0).
- bit_txd_o is registered. It is sr[7] in WRITE, ack_in_i in the ACK phase of a read, and 1 otherwise.
- FSM is one-hot or enumerated; transitions are taken on bit_ack_i except where IDLE says otherwise.
  - IDLE, on go (taken without waiting for bit_ack_i), priority start > read > write > stop: to START/cmd START, READ/cmd READ, WRITE/cmd WRITE, or STOP/cmd STOP. Load the shift register.
  - START: to READ/cmd READ if read_i, else WRITE/cmd WRITE. Load the shift register.
  - WRITE: if cnt_done, go to ACK with cmd READ (sample slave ACK). Else shift and stay, cmd WRITE.
  - READ: shift in bit_rxd_i. If cnt_done, go to ACK with cmd WRITE, bit_txd_o = ack_in_i. Else stay, cmd READ.
  - ACK: ack_out_o <= bit_rxd_i. If stop_i, go to STOP/cmd STOP. Else go to IDLE/cmd NOP with cmd_ack_o = 1.
  - STOP: to IDLE/cmd NOP, cmd_ack_o = 1.
- Latency: cmd_ack_o is asserted 1 cycle after the final bit_ack_i. A full byte is 9 bit commands, plus 1 for START, plus 1 for STOP.
- Arbitration lost (bit_al_i = 1), or ena_i = 0:
  - Next cycle: state IDLE, bit_cmd_o NOP, sr 0, cnt 0, cmd_ack_o 0.
  - ack_out_o keeps its value.
  - No cmd_ack_o is issued for the aborted request.
- bit_ack_i while in IDLE is ignored.
- Reset mid-byte returns to reset values immediately (asynchronous).

Optional Feature:
- Macro I2C_BYTE_TIMEOUT_EN.
- When defined:
  - A TIMEOUT_W-bit counter clears on every bit_ack_i and on entry to IDLE, and increments while state != IDLE.
  - At all-ones it pulses timeout_o for 1 cycle and aborts exactly as on arbitration lost (bit_cmd_o NOP, state IDLE).
- When undefined: no counter; timeout_o is tied 0.

Decomposition:
- Shared package/define file: I2C_CMD_NOP/START/STOP/WRITE/READ, and the byte-FSM state enum (ST_IDLE, ST_START, ST_READ, ST_WRITE, ST_ACK, ST_STOP).
- No sub-module; the 8-bit shift/count datapath stays inline.
- The bit controller is a sibling, connected at the core top.

Test Plan:
- start_i = 1, write_i = 1, din_i = 8'hA5, bit ack model with slave ACK = 0:
  - bit_cmd_o sequence is START, WRITE×8, READ.
  - bit_txd_o bits are 1,0,1,0,0,1,0,1.
  - cmd_ack_o is a single pulse; ack_out_o = 0.
- read_i = 1, ack_in_i = 1, stop_i = 1, bit_rxd_i stream 0x3C:
  - Commands: READ×8, WRITE (bit_txd_o = 1), STOP.
  - dout_o = 8'h3C; cmd_ack_o after STOP ack.
- stop_i only: one STOP command, then cmd_ack_o. Write with slave NACK: ack_out_o = 1.
- bit_al_i pulsed after the 3rd write bit_ack_i: next cycle IDLE, bit_cmd_o = NOP, no cmd_ack_o, i2c_al_o follows bit_al_i.
- Requests held after cmd_ack_o: no new transfer starts in the ack cycle. ena_i dropped mid-read: return to IDLE.
- With I2C_BYTE_TIMEOUT_EN, TIMEOUT_W = 4, bit_ack_i withheld after WRITE issued: timeout_o pulses after 15 cycles, FSM returns to IDLE.
